// File: rtl/cello_truth_sweeper.sv
// Exhaustive 4-input truth-table sweeper for a Cello 2 logic design under test.
// Optional macro SWEEP_GRAY_EN selects Gray-order vectors instead of binary order.
module cello_truth_sweeper #(
    parameter logic [15:0] EXPECTED      = 16'h7BF8,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          SCNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    input  logic        dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_map,
    output logic [4:0]  fail_cnt
);

    localparam int                N_EFF     = (SETTLE_CYCLES < 2) ? 2 : SETTLE_CYCLES;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(N_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          idx;
    logic [SCNT_W-1:0]   scnt;
    logic                sync_p0, sync_q;
    logic [3:0]          vec_cur;
    logic                busy_st, abort_hit, mismatch;

    function automatic logic [3:0] vec_of(input logic [3:0] i);
`ifdef SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // dut_out is asynchronous to clk; the settle window (>= 2) covers this latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync_p0 <= dut_out;
            sync_q  <= sync_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        vec_cur   = vec_of(idx);
        busy_st   = (state == S_APPLY) || (state == S_SETTLE) || (state == S_SAMPLE);
        abort_hit = busy_st && abort;
        mismatch  = (sync_q != EXPECTED[vec_cur]);
        case (state)
            S_IDLE:   if (start && !abort) state_nxt = S_APPLY;
            S_APPLY:  state_nxt = abort ? S_IDLE : S_SETTLE;
            S_SETTLE: begin
                if (abort)                  state_nxt = S_IDLE;
                else if (scnt == SCNT_LAST) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)             state_nxt = S_IDLE;
                else if (idx == 4'hF)  state_nxt = S_DONE;
                else                   state_nxt = S_APPLY;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered: each state's actions become visible one edge after it is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {in1, in2, in3, in4} <= 4'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_map <= 16'h0000;
            fail_cnt <= 5'd0;
            idx      <= 4'h0;
            scnt     <= '0;
        end else begin
            done <= 1'b0;
            if (abort_hit) begin
                {in1, in2, in3, in4} <= 4'h0;
                busy <= 1'b0;
                pass <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            fail_map <= 16'h0000;
                            fail_cnt <= 5'd0;
                            pass     <= 1'b0;
                            idx      <= 4'h0;
                        end
                    end
                    S_APPLY: begin
                        {in1, in2, in3, in4} <= vec_cur;
                        busy <= 1'b1;
                        scnt <= '0;
                    end
                    S_SETTLE: scnt <= scnt + 1'b1;
                    S_SAMPLE: begin
                        if (mismatch) begin
                            fail_map[vec_cur] <= 1'b1;
                            fail_cnt          <= fail_cnt + 5'd1;
                        end
                        if (idx != 4'hF) idx <= idx + 4'h1;
                    end
                    S_DONE: begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        pass <= (fail_cnt == 5'd0);
                        {in1, in2, in3, in4} <= 4'h0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cello_truth_sweeper.sv
// Directed bench for cello_truth_sweeper with SETTLE_CYCLES=4 (6 cycles per vector).
// Honours SWEEP_GRAY_EN to choose the expected vector order.
module tb_cello_truth_sweeper;

    localparam logic [15:0] EXP_TBL = 16'h7BF8;
    localparam int          P       = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in1, in2, in3, in4;
    logic        dut_out;
    logic        busy, done, pass;
    logic [15:0] fail_map;
    logic [4:0]  fail_cnt;

    int          mode = 0;
    int          ntests = 0;
    int          nfail = 0;

    logic [3:0]  vin;
    assign vin     = {in1, in2, in3, in4};
    assign dut_out = (mode == 1) ? 1'b0 : (EXP_TBL[vin] ^ (mode == 2));

    cello_truth_sweeper #(
        .EXPECTED(16'h7BF8),
        .SETTLE_CYCLES(4),
        .SCNT_W(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .fail_map(fail_map), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_vec(input int k);
        logic [3:0] b;
        b = 4'(k);
`ifdef SWEEP_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in"}, 32'(vin), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_pass"}, 32'(pass), 32'h0);
        check({tag, "_map"}, 32'(fail_map), 32'h0);
        check({tag, "_cnt"}, 32'(fail_cnt), 32'h0);
    endtask

    task automatic run_sweep(input int md, input bit spam, input bit abort_done,
                             input logic [15:0] emap, input logic [4:0] ecnt, input logic epass);
        int e, done_edge;
        logic [3:0] prev;
        mode = md;
        done_edge = 0;
        prev = 4'h0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            start = spam && (e == 10 || e == 50 || e == 95);
            abort = abort_done && (e == 16 * P);
            if (e % P == 2 && e / P < 16) begin
                check($sformatf("vec%0d", e / P), 32'(vin), 32'(exp_vec(e / P)));
`ifdef SWEEP_GRAY_EN
                if (e / P > 0) check("gray_hamming", 32'($countones(vin ^ prev)), 32'd1);
`endif
                prev = vin;
            end
            if (done) begin
                done_edge = e;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        check("done_edge", 32'(done_edge), 32'(16 * P + 1));
        check("busy_at_done", 32'(busy), 32'h0);
        check("in_at_done", 32'(vin), 32'h0);
        check("pass", 32'(pass), 32'(epass));
        check("fail_map", 32'(fail_map), 32'(emap));
        check("fail_cnt", 32'(fail_cnt), 32'(ecnt));
        @(posedge clk);
        #1 check("done_pulse_end", 32'(done), 32'h0);
    endtask

    initial begin
        int dcount;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        run_sweep(0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1);
        run_sweep(1, 1'b0, 1'b1, 16'h7BF8, 5'd11, 1'b0);
        run_sweep(2, 1'b0, 1'b0, 16'hFFFF, 5'd16, 1'b0);

        // abort and start together in IDLE: abort wins
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        repeat (3) @(posedge clk);
        #1 check("abort_start_busy", 32'(busy), 32'h0);
        check("abort_start_map_kept", 32'(fail_map), 32'hFFFF);

        // abort during SETTLE of vector 5
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (32) @(posedge clk);
        #1 check("pre_abort_busy", 32'(busy), 32'h1);
        check("pre_abort_vec", 32'(vin), 32'(exp_vec(5)));
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_in", 32'(vin), 32'h0);
        dcount = 0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1 if (done) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'h0);
        check("abort_cnt", 32'(fail_cnt), 32'h0);
        check("abort_pass", 32'(pass), 32'h0);

        // reset asserted mid-sweep with failures recorded
        mode = 2;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("pre_rst_map_nonzero", 32'(fail_map != 16'h0), 32'h1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (done || busy) dcount++;
        end
        check("rst_idle", 32'(dcount), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        run_sweep(0, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
